// File: rtl/atmega_tim_prescaler.sv
// Shared ATmega timer prescaler and external T-pin edge sampler.
// Decodes GTCCR writes on the IO and data buses to apply PSRSYNC and TSM.
`timescale 1ns/1ps
module atmega_tim_prescaler #(
   parameter          PLATFORM          = "XILINX",
   parameter          USE_EXT_T         = "TRUE",
   parameter int      BUS_ADDR_IO_LEN   = 6,
   parameter int      BUS_ADDR_DATA_LEN = 8,
   parameter int      GTCCR_ADDR        = 'h23
) (
   input  logic                         rst,
   input  logic                         clk,
   input  logic [BUS_ADDR_IO_LEN-1:0]   addr_io,
   input  logic                         wr_io,
   input  logic [7:0]                   bus_io_in,
   input  logic [BUS_ADDR_DATA_LEN-1:0] addr_dat,
   input  logic                         wr_dat,
   input  logic [7:0]                   bus_dat_in,
   input  logic                         t,
   output logic                         clk8,
   output logic                         clk64,
   output logic                         clk256,
   output logic                         clk1024,
   output logic                         t_rise,
   output logic                         t_fall,
   output logic                         psrsync_stat
);

   localparam logic [BUS_ADDR_IO_LEN-1:0]   GTCCR_IO  = BUS_ADDR_IO_LEN'(GTCCR_ADDR);
   localparam logic [BUS_ADDR_DATA_LEN-1:0] GTCCR_DAT = BUS_ADDR_DATA_LEN'(GTCCR_ADDR + 'h20);

   logic       gtccr_io_hit;
   logic       gtccr_dat_hit;
   logic       gtccr_wr;
   logic [7:0] gtccr_wdata;
   logic       unused_wdata;

   assign gtccr_io_hit  = wr_io  && (addr_io  == GTCCR_IO);
   assign gtccr_dat_hit = wr_dat && (addr_dat == GTCCR_DAT);
   assign gtccr_wr      = gtccr_io_hit || gtccr_dat_hit;
   // IO bus wins when both buses hit GTCCR in the same cycle.
   assign gtccr_wdata   = gtccr_io_hit ? bus_io_in : bus_dat_in;
   assign unused_wdata  = ^gtccr_wdata[6:1];

   logic [9:0] cnt_q, cnt_d;
   logic       tsm_q, tsm_d;
   logic       psr_hold_q, psr_hold_d;
   logic       frozen;

   assign frozen = tsm_q & psr_hold_q;

   always_comb begin
      cnt_d      = frozen ? cnt_q : cnt_q + 10'd1;
      tsm_d      = tsm_q;
      // Without TSM a pending PSRSYNC lasts only one cycle.
      psr_hold_d = psr_hold_q & tsm_q;
      if (gtccr_wr) begin
         tsm_d = gtccr_wdata[7];
         if (gtccr_wdata[0]) begin
            cnt_d      = '0;
            psr_hold_d = 1'b1;
         end else if (!gtccr_wdata[7]) begin
            psr_hold_d = 1'b0;
         end else begin
            psr_hold_d = psr_hold_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q      <= '0;
         tsm_q      <= 1'b0;
         psr_hold_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         tsm_q      <= tsm_d;
         psr_hold_q <= psr_hold_d;
      end
   end

   assign clk8         = cnt_q[2];
   assign clk64        = cnt_q[5];
   assign clk256       = cnt_q[7];
   assign clk1024      = cnt_q[9];
   assign psrsync_stat = psr_hold_q;

   generate
      if (USE_EXT_T == "TRUE") begin : g_ext_t
         logic sync1_q, sync1_d;
         logic sync2_q, sync2_d;
         logic t_del_q, t_del_d;
         logic t_rise_q, t_rise_d;
         logic t_fall_q, t_fall_d;

         always_comb begin
            sync1_d  = t;
            sync2_d  = sync1_q;
            t_del_d  = sync2_q;
            t_rise_d = sync2_q & ~t_del_q;
            t_fall_d = ~sync2_q & t_del_q;
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sync1_q  <= 1'b0;
               sync2_q  <= 1'b0;
               t_del_q  <= 1'b0;
               t_rise_q <= 1'b0;
               t_fall_q <= 1'b0;
            end else begin
               sync1_q  <= sync1_d;
               sync2_q  <= sync2_d;
               t_del_q  <= t_del_d;
               t_rise_q <= t_rise_d;
               t_fall_q <= t_fall_d;
            end
         end

         assign t_rise = t_rise_q;
         assign t_fall = t_fall_q;
      end else begin : g_no_ext_t
         logic unused_t;
         assign unused_t = t;
         assign t_rise   = 1'b0;
         assign t_fall   = 1'b0;
      end

      // Reserved for vendor-specific synchroniser attributes.
      if (PLATFORM == "XILINX") begin : g_plat_xilinx
      end else begin : g_plat_generic
      end
   endgenerate

endmodule

// File: tb/tb_atmega_tim_prescaler.sv
// Randomised self-checking bench for atmega_tim_prescaler against a counter/history model.
// Two instances share stimulus: one with the T-pin sampler, one without.
`timescale 1ns/1ps
module tb_atmega_tim_prescaler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] addr_io = '0;
   logic       wr_io = 1'b0;
   logic [7:0] bus_io_in = '0;
   logic [7:0] addr_dat = '0;
   logic       wr_dat = 1'b0;
   logic [7:0] bus_dat_in = '0;
   logic       t = 1'b0;

   logic a_clk8, a_clk64, a_clk256, a_clk1024, a_t_rise, a_t_fall, a_psr;
   logic b_clk8, b_clk64, b_clk256, b_clk1024, b_t_rise, b_t_fall, b_psr;
   logic [6:0] a_vec, b_vec;

   assign a_vec = {a_clk8, a_clk64, a_clk256, a_clk1024, a_psr, a_t_rise, a_t_fall};
   assign b_vec = {b_clk8, b_clk64, b_clk256, b_clk1024, b_psr, b_t_rise, b_t_fall};

   atmega_tim_prescaler #(.USE_EXT_T("TRUE")) dut_a (
      .rst(rst), .clk(clk), .addr_io(addr_io), .wr_io(wr_io), .bus_io_in(bus_io_in),
      .addr_dat(addr_dat), .wr_dat(wr_dat), .bus_dat_in(bus_dat_in), .t(t),
      .clk8(a_clk8), .clk64(a_clk64), .clk256(a_clk256), .clk1024(a_clk1024),
      .t_rise(a_t_rise), .t_fall(a_t_fall), .psrsync_stat(a_psr)
   );

   atmega_tim_prescaler #(.USE_EXT_T("FALSE")) dut_b (
      .rst(rst), .clk(clk), .addr_io(addr_io), .wr_io(wr_io), .bus_io_in(bus_io_in),
      .addr_dat(addr_dat), .wr_dat(wr_dat), .bus_dat_in(bus_dat_in), .t(t),
      .clk8(b_clk8), .clk64(b_clk64), .clk256(b_clk256), .clk1024(b_clk1024),
      .t_rise(b_t_rise), .t_fall(b_t_fall), .psrsync_stat(b_psr)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: integer tick count, prescaler-reset flags, t history by edge.
   int m_cnt;
   bit m_tsm;
   bit m_hold;
   bit t_hist[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt  = 0;
      m_tsm  = 1'b0;
      m_hold = 1'b0;
      t_hist = '{1'b0, 1'b0, 1'b0, 1'b0};
   endtask

   task automatic model_edge();
      bit w_io, w_dat, frozen;
      logic [7:0] d;
      w_io   = wr_io && (addr_io == 6'h23);
      w_dat  = wr_dat && (addr_dat == 8'h43);
      frozen = m_hold && m_tsm;
      if (w_io || w_dat) begin
         d = w_io ? bus_io_in : bus_dat_in;
         if (d[0]) begin
            m_cnt  = 0;
            m_hold = 1'b1;
         end else begin
            if (!d[7]) m_hold = 1'b0;
            if (!frozen) m_cnt = (m_cnt + 1) % 1024;
         end
         m_tsm = d[7];
      end else begin
         if (!frozen) m_cnt = (m_cnt + 1) % 1024;
         if (m_hold && !m_tsm) m_hold = 1'b0;
      end
      t_hist.push_back(t);
      void'(t_hist.pop_front());
   endtask

   // t_hist[3] is t seen at this edge; a pulse reflects t two edges earlier.
   function automatic logic [6:0] expected_vec(input bit with_t);
      bit rise, fall;
      rise = t_hist[1] && !t_hist[0];
      fall = !t_hist[1] && t_hist[0];
      return {(m_cnt % 8) >= 4, (m_cnt % 64) >= 32, (m_cnt % 256) >= 128, m_cnt >= 512,
              m_hold, with_t && rise, with_t && fall};
   endfunction

   task automatic do_cycle();
      @(posedge clk);
      model_edge();
      #1;
      check_eq("out_ext", 32'(a_vec), 32'(expected_vec(1'b1)));
      check_eq("out_noext", 32'(b_vec), 32'(expected_vec(1'b0)));
      wr_io  = 1'b0;
      wr_dat = 1'b0;
   endtask

   task automatic run_to_cnt(input int target);
      int guard;
      guard = 0;
      while (m_cnt != target && guard < 2100) begin
         do_cycle();
         guard++;
      end
      check_eq("reach_cnt", 32'(m_cnt), 32'(target));
   endtask

   function automatic logic [7:0] pick_data();
      int s;
      s = $urandom_range(0, 5);
      case (s)
         0: return 8'h01;
         1: return 8'h81;
         2: return 8'h00;
         3: return 8'h80;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rises[4];
      int first8, first1024, fall1024, k, rise_at, fall_at, n_rise;
      logic [3:0] prev, cur;

      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_ext", 32'(a_vec), 32'd0);
      check_eq("reset_noext", 32'(b_vec), 32'd0);
      rst = 1'b0;

      // Idle run from reset release
      rises = '{0, 0, 0, 0};
      prev = '0;
      first8 = -1; first1024 = -1; fall1024 = -1;
      for (int i = 1; i <= 2048; i++) begin
         do_cycle();
         cur = {a_clk1024, a_clk256, a_clk64, a_clk8};
         for (int j = 0; j < 4; j++) if (cur[j] && !prev[j]) rises[j]++;
         if (cur[0] && !prev[0] && first8 < 0) first8 = i;
         if (cur[3] && !prev[3] && first1024 < 0) first1024 = i;
         if (!cur[3] && prev[3] && fall1024 < 0) fall1024 = i;
         prev = cur;
      end
      check_eq("first_clk8", 32'(first8), 32'd4);
      check_eq("first_clk1024", 32'(first1024), 32'd512);
      check_eq("fall_clk1024", 32'(fall1024), 32'd1024);
      check_eq("n_clk8", 32'(rises[0]), 32'd256);
      check_eq("n_clk64", 32'(rises[1]), 32'd32);
      check_eq("n_clk256", 32'(rises[2]), 32'd8);
      check_eq("n_clk1024", 32'(rises[3]), 32'd2);

      // PSRSYNC via IO bus at cnt=37
      run_to_cnt(37);
      addr_io = 6'h23; bus_io_in = 8'h01; wr_io = 1'b1;
      do_cycle();
      check_eq("psr_set", 32'(a_psr), 32'd1);
      do_cycle();
      check_eq("psr_selfclr", 32'(a_psr), 32'd0);
      k = 2;
      while (!a_clk8 && k < 20) begin
         do_cycle();
         k++;
      end
      check_eq("clk8_after_psr", 32'(k), 32'd5);

      // TSM hold via data bus alias
      addr_dat = 8'h43; bus_dat_in = 8'h81; wr_dat = 1'b1;
      do_cycle();
      for (int i = 0; i < 100; i++) begin
         do_cycle();
         check_eq("hold_clk", 32'({a_clk8, a_clk64, a_clk256, a_clk1024}), 32'd0);
         check_eq("hold_psr", 32'(a_psr), 32'd1);
      end
      addr_dat = 8'h43; bus_dat_in = 8'h00; wr_dat = 1'b1;
      do_cycle();
      check_eq("release_psr", 32'(a_psr), 32'd0);
      repeat (4) do_cycle();
      check_eq("restart_clk8", 32'(a_clk8), 32'd1);

      // Simultaneous bus writes: IO data wins
      addr_io = 6'h23; bus_io_in = 8'h00; wr_io = 1'b1;
      addr_dat = 8'h43; bus_dat_in = 8'h81; wr_dat = 1'b1;
      do_cycle();
      check_eq("both_psr", 32'(a_psr), 32'd0);
      repeat (8) do_cycle();

      // T pulse of 10 cycles
      rise_at = -1; fall_at = -1;
      t = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (i == 10) t = 1'b0;
         do_cycle();
         if (a_t_rise && rise_at < 0) rise_at = i;
         if (a_t_fall && fall_at < 0) fall_at = i;
      end
      check_eq("t_rise_lat", 32'(rise_at), 32'd2);
      check_eq("t_fall_lat", 32'(fall_at), 32'd12);

      // Reset mid-operation at cnt=600 with t high
      t = 1'b1;
      run_to_cnt(600);
      rst = 1'b1;
      #2;
      check_eq("midrst_ext", 32'(a_vec), 32'd0);
      check_eq("midrst_noext", 32'(b_vec), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      rise_at = -1; n_rise = 0;
      for (int i = 0; i < 8; i++) begin
         do_cycle();
         if (a_t_rise) begin
            n_rise++;
            if (rise_at < 0) rise_at = i;
         end
      end
      check_eq("rst_t_rise_lat", 32'(rise_at), 32'd2);
      check_eq("rst_t_rise_cnt", 32'(n_rise), 32'd1);

      // Random bus traffic and pin activity
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 4) begin
            addr_io = $urandom_range(0, 1) ? 6'h23 : 6'($urandom);
            bus_io_in = pick_data();
            wr_io = 1'b1;
         end
         if ($urandom_range(0, 99) < 4) begin
            addr_dat = $urandom_range(0, 1) ? 8'h43 : 8'($urandom);
            bus_dat_in = pick_data();
            wr_dat = 1'b1;
         end
         if ($urandom_range(0, 9) == 0) t = ~t;
         do_cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/atmega_tim_prescaler.md
Name: atmega_tim_prescaler

Overview:
- Shared clock prescaler and external-T-pin sampler that feeds the ATmega 8-bit and 16-bit timer blocks.
- Generates the clk8/clk64/clk256/clk1024 tick sources and the synchronised T-pin edge pulses that the timer clock-select mux consumes.
- Honours GTCCR PSRSYNC/TSM by snooping CPU writes on the IO and data buses.

Parameters:
- PLATFORM, "XILINX", target family tag; no functional effect.
- USE_EXT_T, "TRUE", "TRUE" instantiates the T-pin sampler; any other value ties t_rise and t_fall to 0.
- BUS_ADDR_IO_LEN, 6, IO address width.
- BUS_ADDR_DATA_LEN, 8, data address width.
- GTCCR_ADDR, 'h23, IO address of GTCCR; data-space alias is GTCCR_ADDR+'h20.

Ports:
- rst  input  1  asynchronous, active-high reset.
- clk  input  1  IO core clock; the only clock.
- addr_io  input  BUS_ADDR_IO_LEN  IO bus address.
- wr_io  input  1  IO write strobe.
- bus_io_in  input  8  IO write data.
- addr_dat  input  BUS_ADDR_DATA_LEN  data bus address.
- wr_dat  input  1  data write strobe.
- bus_dat_in  input  8  data write data.
- t  input  1  asynchronous external timer pin.
- clk8  output  1  prescaler bit, one rising edge per 8 clk.
- clk64  output  1  one rising edge per 64 clk.
- clk256  output  1  one rising edge per 256 clk.
- clk1024  output  1  one rising edge per 1024 clk.
- t_rise  output  1  one-cycle pulse on a synchronised rising edge of t.
- t_fall  output  1  one-cycle pulse on a synchronised falling edge of t.
- psrsync_stat  output  1  current PSRSYNC state, for the GTCCR read mux.

Behaviour:
- Reset:
  - All registers clear asynchronously: cnt[9:0]=0, tsm=0, psr_hold=0, sync1=sync2=t_del=0.
  - All outputs are 0 during reset.
- Counter:
  - cnt is 10 bits and increments by 1 on every clk edge unless it is held or cleared.
  - Wrap-around: 1023 -> 0.
  - Output mapping, all driven directly from cnt register bits:
    - clk8 = cnt[2]
    - clk64 = cnt[5]
    - clk256 = cnt[7]
    - clk1024 = cnt[9]
  - First rising edges after reset release:
    - clk8 rises on the 4th edge, then every 8 edges.
    - clk64 rises on the 32nd edge.
    - clk256 rises on the 128th edge.
    - clk1024 rises on the 512th edge, falls at the wrap.
- GTCCR snoop:
  - A GTCCR write is either of:
    - wr_io=1 with addr_io==GTCCR_ADDR.
    - wr_dat=1 with addr_dat==GTCCR_ADDR+'h20.
  - If both buses write GTCCR in the same cycle, the IO bus data is used.
- Write with bit0 (PSRSYNC)=1:
  - cnt <= 0 on that edge.
  - psr_hold <= 1.
  - tsm <= bit7.
- Write with bit0=0:
  - tsm <= bit7.
  - psr_hold is unchanged if bit7=1; psr_hold is cleared if bit7=0.
- Hold and release:
  - While tsm=1 and psr_hold=1, cnt is held at 0 and all clkN stay 0.
  - While tsm=0 and psr_hold=1, psr_hold self-clears on the next edge, so psrsync_stat is high for exactly 1 cycle. Counting resumes on that same edge (cnt 0 -> 1).
  - Writing TSM=0 during a hold releases it: cnt counts from the next edge.
  - A PSRSYNC write has priority over the increment in the same cycle.
- T-pin sampler (USE_EXT_T=="TRUE"):
  - Pipeline: sync1 <= t, sync2 <= sync1, t_del <= sync2.
  - t_rise <= sync2 & ~t_del; t_fall <= ~sync2 & t_del. Both are registered.
  - Latency: t changes before edge E0 -> pulse is high for exactly the one cycle after edge E2.
  - A pulse width below one clk period may be missed; no requirement applies to it.
  - Reset values are 0, so t held high through reset release produces one t_rise pulse after E2.
  - The sampler is unaffected by PSRSYNC/TSM.
- Reset mid-operation: a rst assertion clears cnt, hold state and the sampler immediately. A pulse in flight is aborted.

Test Plan:
- Release reset, idle 2048 clocks:
  - clk8 first rises at edge 4, period 8.
  - clk1024 first rises at edge 512, falls at edge 1024.
  - Edge counts: 256 clk8, 32 clk64, 8 clk256, 2 clk1024.
- At cnt=37, IO write GTCCR=8'h01:
  - cnt=0 after that edge.
  - psrsync_stat=1 for 1 cycle.
  - cnt=1 after the following edge.
  - clk8 next rises 5 edges after the write.
- Data write to 'h43 with 8'h81, hold 100 cycles, then write 8'h00:
  - cnt=0 and all clkN=0 throughout the hold.
  - psrsync_stat=1 during the hold, 0 one cycle after the release write.
  - Counting restarts after the release write.
- Same cycle, wr_io GTCCR=8'h00 and wr_dat 'h43=8'h81 -> IO data applied: no clear, tsm=0.
- t 0->1 before E0, back to 0 after 10 cycles:
  - t_rise high only after E2.
  - t_fall high exactly 10 cycles later.
  - With USE_EXT_T="FALSE", both pulses stay 0.
- Assert rst for 1 cycle at cnt=600 with t high:
  - All outputs 0 immediately.
  - After release, cnt counts from 0 and one t_rise pulse appears after E2.
